// File: rtl/tile_feeder.sv
// tile_feeder: skews activation columns into a systolic array's row-0 PEs and sequences one tile.
// Define FEEDER_PERF_EN to build the STREAM bubble counter behind stall_cnt_o.
module tile_feeder #(
    parameter int ROWS         = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int K_MAX        = 16,
    parameter int DRAIN_CYCLES = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data_i,
    input  logic                       in_last_i,
    output logic [ROWS*DATA_WIDTH-1:0] a_row_o,
    output logic                       adv_o,
    output logic                       reset_sys_o,
    output logic                       busy_o,
    output logic                       tile_done_o,
    output logic                       overrun_o,
    output logic [15:0]                stall_cnt_o
);
    localparam int CW = $clog2(K_MAX + 1);
    localparam int FW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fl_q, fl_d;
    logic overrun_q, overrun_d, reset_sys_q, accept, term;
    assign accept      = in_valid_i & in_ready_o;
    assign adv_o       = accept;
    // a tile ends on in_last or on the beat that reaches K_MAX
    assign term        = accept & (in_last_i | (cnt_q == CW'(K_MAX - 1)));
    assign overrun_o   = overrun_q;
    assign reset_sys_o = reset_sys_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? CLEAR : IDLE;
            CLEAR:   state_d = STREAM;
            STREAM:  state_d = term ? FLUSH : STREAM;
            FLUSH:   state_d = (fl_q == FW'(DRAIN_CYCLES - 1)) ? DONE : FLUSH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready_o  = state_q == STREAM;
        busy_o      = state_q != IDLE;
        tile_done_o = state_q == DONE;
    end
    always_comb begin
        cnt_d     = (state_q == CLEAR) ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
        fl_d      = (state_q == FLUSH) ? fl_q + FW'(1) : '0;
        overrun_d = (state_q == CLEAR) ? 1'b0 : overrun_q | (term & ~in_last_i);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            fl_q        <= '0;
            overrun_q   <= 1'b0;
            reset_sys_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fl_q        <= fl_d;
            overrun_q   <= overrun_d;
            reset_sys_q <= state_d == CLEAR;
        end
    end
    // row r is delayed r+1 cycles; idle cycles shift in zeros
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] pipe_q [r+1];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k <= r; k++) pipe_q[k] <= '0;
            end else begin
                pipe_q[0] <= accept ? in_data_i[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= r; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end
        assign a_row_o[r*DATA_WIDTH +: DATA_WIDTH] = pipe_q[r];
    end
`ifdef FEEDER_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                                  stall_q <= '0;
        else if (state_q == CLEAR)                                    stall_q <= '0;
        else if (state_q == STREAM && !in_valid_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tile_feeder.sv
// tb_tile_feeder: vector table plus directed tiles; a per-row scoreboard predicts every a_row slice each cycle.
module tb_tile_feeder;
    localparam int ROWS = 4;
    localparam int DW   = 8;
`ifdef FEEDER_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
    logic [ROWS*DW-1:0] in_data = '0;
    logic [ROWS*DW-1:0] a_row;
    logic in_ready, adv, reset_sys, busy, tile_done, overrun;
    logic [15:0] stall_cnt;
    int n_cmp = 0, n_fail = 0, cyc_n = 0;

    typedef struct { int due; logic [DW-1:0] val; } ent_t;
    ent_t rq [ROWS][$];

    typedef struct {
        logic s, v; logic [31:0] d; logic l;
        logic er, eb, ers, ed;
    } vec_t;
    vec_t tbl [13];

    tile_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .K_MAX(16), .DRAIN_CYCLES(7)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .a_row_o(a_row), .adv_o(adv), .reset_sys_o(reset_sys), .busy_o(busy),
        .tile_done_o(tile_done), .overrun_o(overrun), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                logic [DW-1:0] e;
                e = '0;
                if (rq[r].size() > 0 && rq[r][0].due == cyc_n) e = rq[r].pop_front().val;
                chk($sformatf("a_row[%0d]", r), 32'(a_row[r*DW +: DW]), 32'(e));
            end
        end
    end

    task automatic cyc(input logic s, input logic v, input logic [31:0] d, input logic l, input logic er);
        @(posedge clk); #1;
        start = s; in_valid = v; in_data = d; in_last = l;
        if (v && er)
            for (int r = 0; r < ROWS; r++) rq[r].push_back('{due: cyc_n + 1 + r, val: d[r*DW +: DW]});
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("adv", 32'(adv), 32'(v & er));
    endtask

    task automatic wait_done(input int exp_n, input logic v);
        int n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            cyc(0, v, 32'hdeadbeef, 0, 0);
            if (tile_done) n = i;
        end
        chk("done_latency", 32'(n), 32'(exp_n));
        cyc(0, 0, 0, 0, 0);
        chk("done_pulse_end", 32'(tile_done), 0);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 0, 32'h0,        0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 32'haaaaaaaa, 0, 0, 1, 1, 0};
        tbl[2]  = '{0, 1, 32'h04030201, 1, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 32'h55555555, 0, 0, 1, 0, 0};
        tbl[4]  = '{1, 0, 32'h0,        0, 0, 1, 0, 0};
        for (int i = 5; i < 10; i++) tbl[i] = '{0, 0, 32'h0, 0, 0, 1, 0, 0};
        tbl[10] = '{1, 0, 32'h0,        0, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 32'h0,        0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 32'h0,        0, 0, 0, 0, 0};

        #3;
        chk("rst_a_row", a_row, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_reset_sys", 32'(reset_sys), 0);
        chk("rst_tile_done", 32'(tile_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        @(posedge clk); #2 rst_n = 1;

        // single-beat skew tile, clear sequencing, ignored starts in FLUSH and DONE
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].er);
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("reset_sys[%0d]", i), 32'(reset_sys), 32'(tbl[i].ers));
            chk($sformatf("tile_done[%0d]", i), 32'(tile_done), 32'(tbl[i].ed));
        end
        chk("overrun_normal", 32'(overrun), 0);

        // bubble: A, none, B
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h88776655, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 32'h00ff10ee, 1, 1);
        wait_done(8, 0);
        chk("stall_bubble", 32'(stall_cnt), 32'(PERF));

        // overrun: 16 beats without in_last
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, $urandom, 0, 1);
        wait_done(8, 1);
        chk("overrun_set", 32'(overrun), 1);
        cyc(1, 0, 0, 0, 0);
        chk("overrun_sticky", 32'(overrun), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0a0b0c0d, 1, 1);
        chk("overrun_cleared", 32'(overrun), 0);
        wait_done(8, 0);

        // asynchronous reset mid-STREAM
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h11223344 + i, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        @(posedge clk); #1;
        start = 0; in_valid = 0; in_last = 0;
        rst_n = 0;
        for (int r = 0; r < ROWS; r++) rq[r].delete();
        #1;
        chk("mid_rst_a_row", a_row, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_stall", 32'(stall_cnt), 0);
        @(posedge clk); #2 rst_n = 1;
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_busy", 32'(busy), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_clear", 32'(reset_sys), 1);
        cyc(0, 1, 32'h01020304, 0, 1);
        cyc(0, 1, 32'hf0e0d0c0, 1, 1);
        wait_done(8, 0);
        chk("post_rst_stall", 32'(stall_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_feeder.md
TILE_FEEDER -- requirements
Module: tile_feeder

Interface
REQ-001 Parameter ROWS, default 4, number of systolic-array rows fed (range 2..16).
REQ-002 Parameter DATA_WIDTH, default 8, activation element width; equals the array's a_in width.
REQ-003 Parameter K_MAX, default 16, maximum beats per tile.
REQ-004 Parameter DRAIN_CYCLES, default 7, zero-fill cycles after the last beat.
REQ-005 The block SHALL have exactly one clock and one reset: clk input 1 rising-edge clock, first; reset input 1 asynchronous active-low reset, second.
REQ-006 start input 1: single-cycle tile launch request.
REQ-007 in_valid input 1: in_data/in_last valid.
REQ-008 in_ready output 1: block accepts a beat.
REQ-009 in_data input ROWS*DATA_WIDTH: one activation column; row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_last input 1: final beat of the tile.
REQ-011 a_row output ROWS*DATA_WIDTH: skewed activations to the array's row-0 PEs, row r in slice r.
REQ-012 adv output 1: accepted-beat strobe, used by the companion weight feeder to keep the same bubble pattern.
REQ-013 reset_sys output 1: accumulator clear to all PEs.
REQ-014 busy output 1: state is not IDLE.
REQ-015 tile_done output 1: one-cycle completion pulse.
REQ-016 overrun output 1: sticky; K_MAX beats were accepted without in_last.
REQ-017 stall_cnt output 16: STREAM bubble count (see Configuration).

Function
REQ-018 FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
REQ-019 IDLE->CLEAR on start; CLEAR->STREAM after exactly 1 cycle; STREAM->FLUSH on the cycle after the terminating beat is accepted; FLUSH->DONE after DRAIN_CYCLES cycles; DONE->IDLE after 1 cycle.
REQ-020 reset_sys SHALL be high exactly during CLEAR, registered, and low in every other state.
REQ-021 in_ready SHALL be high only in STREAM; accept = in_valid & in_ready; adv = accept, combinational.
REQ-022 Skew: a beat accepted at cycle t SHALL have row r appear on a_row slice r at cycle t+1+r; row 0 has 1 cycle of latency.
REQ-023 The skew pipeline SHALL shift every cycle; a cycle without an accept, including CLEAR/FLUSH/IDLE, SHALL insert a zero element at row 0.
REQ-024 The beat counter SHALL clear in CLEAR and increment on each accept.
REQ-025 The terminating beat SHALL be an accept with in_last=1, or the accept that makes the beat count equal K_MAX; in the latter case, if in_last=0, overrun SHALL set.
REQ-026 overrun SHALL clear only in CLEAR or on reset.
REQ-027 in_last on the first beat SHALL be legal: a 1-beat tile.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 start in the DONE cycle SHALL be ignored; a new tile needs start in IDLE.
REQ-030 tile_done SHALL be high exactly during DONE.
REQ-031 DRAIN_CYCLES >= ROWS-1 is required so that all skewed data leaves the pipe before DONE.

Reset
REQ-032 Reset assertion SHALL immediately force the following, regardless of state including mid-STREAM: state=IDLE, all skew registers=0, a_row=0, reset_sys=0, tile_done=0, overrun=0, beat counter=0, stall_cnt=0.
REQ-033 After reset deassertion the block SHALL wait in IDLE with in_ready=0 and busy=0.

Configuration
REQ-034 Macro FEEDER_PERF_EN defined: stall_cnt SHALL clear in CLEAR, increment by 1 on each STREAM cycle with in_valid=0, and saturate at 16'hFFFF.
REQ-035 Macro FEEDER_PERF_EN undefined: stall_cnt SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification (ROWS=4, DATA_WIDTH=8, K_MAX=16, DRAIN_CYCLES=7)
REQ-036 Reset mid-STREAM: assert reset 2 cycles after 3 accepts -> a_row=0, busy=0, in_ready=0 that same cycle; a following start runs a clean tile.
REQ-037 Skew check: start, then accept in_data=32'h04030201 at cycle t with in_last=1 -> a_row slices show 01@t+1, 02@t+2, 03@t+3, 04@t+4, zeros elsewhere; tile_done one cycle after 7 FLUSH cycles.
REQ-038 Bubble: beats A, none, B -> adv=1,0,1; row 0 shows A, 0, B on consecutive cycles; stall_cnt=1 with FEEDER_PERF_EN, 0 without.
REQ-039 Overrun: 16 accepts with in_last=0 -> in_ready drops after the 16th, overrun=1, FLUSH follows; the next start's CLEAR clears overrun.
REQ-040 Clear sequencing: start -> reset_sys high for exactly 1 cycle, in_ready rising the next cycle; start pulsed during FLUSH -> no effect.
